loop_replay_buffer: RTL and testbench
=====================================

# loop_replay_buffer

Parametrised loop-stream buffer between fetch and decode. It detects a short backward branch (B-type or JAL), captures one full loop body into a private instruction store, and then replays the body to decode with a valid/ready handshake while fetch is stalled. Replay ends on a backend mispredict, which redirects fetch to the loop fall-through, or on an external flush. It replaces the fixed-size single-pass loop FSM with a configurable depth, multi-iteration replay, backpressure and an iteration counter.

## Interface
- `XLEN`, default 32: PC and immediate width.
- `DEPTH`, default 16: instruction entries; power of 2, range 4..64; max loop length in instructions.
- `ITER_W`, default 8: iteration counter width.
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: fetch presents an instruction this cycle.
- `in_pc` input XLEN: PC of `in_instr`.
- `in_instr` input 32: raw instruction.
- `in_imm` input XLEN: sign-extended branch/JAL offset of `in_instr`.
- `mispredict` input 1: backend branch mispredict, 1-cycle pulse.
- `ext_flush` input 1: exception/trap flush; abandon all loop state.
- `out_ready` input 1: decode accepts replayed instruction.
- `out_valid` output 1: replayed instruction valid.
- `out_pc` output XLEN: PC of replayed instruction.
- `out_instr` output 32: replayed instruction.
- `fetch_stall` output 1: hold fetch; high throughout REPLAY.
- `redirect` output 1: 1-cycle pulse; fetch restarts at `redirect_pc`.
- `redirect_pc` output XLEN: loop_end + 4; valid with `redirect`.
- `loop_active` output 1: state is CAPTURE or REPLAY.
- `iter_count` output ITER_W: completed replay iterations; saturating.

## Operation
- Detection: `in_valid` and opcode is 1100011 or 1101111 and `in_imm[XLEN-1]`=1 and `in_imm[1:0]`=0 and `in_imm` >= -(DEPTH-1)*4. Then loop_end=`in_pc`, loop_start=`in_pc`+`in_imm`, and L=((loop_end-loop_start)>>2)+1, which ranges from 2 to DEPTH. An offset of -DEPTH*4 or larger magnitude is ignored.
- IDLE: on detection, latch loop_start, loop_end and L, then go to ARM.
- ARM: the next `in_valid` with `in_pc`==loop_start goes to CAPTURE and is written as entry 0. Any other `in_valid` PC returns to IDLE.
- CAPTURE: each `in_valid` must have `in_pc`==expected, where expected = loop_start + 4·wr_idx. A match writes entry wr_idx. A mismatch aborts to IDLE with nothing written.
  - The write with `in_pc`==loop_end completes the capture and moves to REPLAY. Only loop_end's own opcode is checked at that write; intermediate branches are captured as ordinary instructions.
- REPLAY: `fetch_stall`=1 and in_* are ignored. rd_idx runs from 0 to L-1, wraps to 0, and `iter_count` increments on the wrap (saturating at 2^ITER_W-1).
  - `out_pc` = loop_start + 4·rd_idx.
  - The output register advances only on `out_valid`&&`out_ready`; while stalled, out_* are held stable.
- `mispredict` in REPLAY goes to EXIT: drop `out_valid` next cycle and do not advance rd_idx. `mispredict` in ARM or CAPTURE returns to IDLE with no redirect.
- EXIT: one cycle with `redirect`=1 and `redirect_pc`=loop_end+4, then IDLE. `iter_count` clears on entering IDLE.
- `ext_flush` has priority over every other event. From any state it goes to IDLE next cycle with no redirect, `out_valid`=0 and `fetch_stall`=0.
- Simultaneous `mispredict` and handshake in REPLAY: the handshake completes but no new entry is loaded.

## Timing
- Reset values: `out_valid`=0, `out_pc`=0, `out_instr`=0, `fetch_stall`=0, `redirect`=0, `redirect_pc`=0, `loop_active`=0, `iter_count`=0. State=IDLE, all indices 0; storage contents are don't-care.
- All outputs are registered.
- Capture writes land at the clock edge of the accepting cycle.
- The first REPLAY cycle loads entry 0, so `out_valid` rises one cycle after entering REPLAY. After that, throughput is 1 instruction per cycle under continuous `out_ready`.
- `fetch_stall` rises on the first REPLAY cycle and falls on the cycle `redirect` pulses.
- `redirect` is asserted exactly 1 cycle after `mispredict` is sampled in REPLAY.
- Reset mid-operation: asynchronous return to IDLE, and all outputs take their reset values immediately.

## Structure
- `loop_replay_pkg` holds:
  - opcode constants BTYPE_OPCODE=7'b1100011 and JAL_OPCODE=7'b1101111;
  - the state enum IDLE, ARM, CAPTURE, REPLAY, EXIT;
  - the index-width function clog2(DEPTH).
- Sub-module `loop_replay_store` is a DEPTH×32 flop array with one synchronous write port and one combinational read port. It has no reset on the data.
- The top level holds the FSM, the PC/index arithmetic and the output register.

## Test plan
- BEQ at 0x1C with imm=-12, followed by fetch 0x10, 0x14, 0x18, 0x1C → L=4, REPLAY. `out_pc` sequence is 0x10, 0x14, 0x18, 0x1C, 0x10…; `iter_count`=1 after the first wrap.
- During replay, pulse `mispredict` → `redirect`=1 the next cycle with `redirect_pc`=0x20. `fetch_stall` falls and `out_valid`=0.
- DEPTH=16: JAL with imm=-60 → L=16, captured and replayed. JAL with imm=-64, or with imm=+8 → stays IDLE.
- In CAPTURE, fetch 0x10 then 0x30 → abort to IDLE and `loop_active`=0. ARM followed by a non-loop_start PC → IDLE.
- In REPLAY, hold `out_ready`=0 for 5 cycles → `out_pc`/`out_instr` stable. On release, the sequence continues with no skipped or duplicated entries.
- Assert `reset` asynchronously mid-REPLAY, and separately pulse `ext_flush` mid-CAPTURE → all outputs at reset values and `redirect` never pulses.

Source files
------------

// File: rtl/loop_replay_pkg.sv
// Shared definitions for the loop replay buffer: opcodes, FSM states and
// the index-width helper used to size the instruction store.
package loop_replay_pkg;

    localparam logic [6:0] BTYPE_OPCODE = 7'b1100011;
    localparam logic [6:0] JAL_OPCODE   = 7'b1101111;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        REPLAY,
        EXIT
    } loop_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic logic isLoopOpcode(input logic [6:0] opcode);
        return (opcode == BTYPE_OPCODE) || (opcode == JAL_OPCODE);
    endfunction

endpackage

// File: rtl/loop_replay_store.sv
// Private instruction store for one captured loop body: one synchronous
// write port, one combinational read port, no reset on the data.
module loop_replay_store
    import loop_replay_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      wrEn_i,
    input  logic [clog2(DEPTH)-1:0]   wrAddr_i,
    input  logic [31:0]               wrData_i,
    input  logic [clog2(DEPTH)-1:0]   rdAddr_i,
    output logic [31:0]               rdData_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem[rdAddr_i];

endmodule

// File: rtl/loop_replay_buffer.sv
// Loop stream buffer: detects a short backward branch, captures one loop
// body and replays it to decode while fetch is stalled.
module loop_replay_buffer
    import loop_replay_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              mispredict,
    input  logic              ext_flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [31:0]       out_instr,
    output logic              fetch_stall,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              loop_active,
    output logic [ITER_W-1:0] iter_count
);

    localparam int IDX_W = clog2(DEPTH);
    localparam logic [XLEN-1:0] MIN_IMM = XLEN'(-(DEPTH - 1) * 4);

    loop_state_e state_q, state_d;

    logic [XLEN-1:0]   loopStart_q, loopStart_d;
    logic [XLEN-1:0]   loopEnd_q, loopEnd_d;
    logic [IDX_W-1:0]  lastIdx_q, lastIdx_d;
    logic [IDX_W-1:0]  wrIdx_q, wrIdx_d;
    logic [IDX_W-1:0]  rdIdx_q, rdIdx_d;
    logic              outValid_q, outValid_d;
    logic [XLEN-1:0]   outPc_q, outPc_d;
    logic [31:0]       outInstr_q, outInstr_d;
    logic              fetchStall_q, fetchStall_d;
    logic              redirect_q, redirect_d;
    logic [XLEN-1:0]   redirectPc_q, redirectPc_d;
    logic              loopActive_q, loopActive_d;
    logic [ITER_W-1:0] iterCount_q, iterCount_d;

    logic              detect;
    logic              opcodeOk;
    logic              pcMatch;
    logic              atEnd;
    logic              storeWrEn;
    logic              atLast;
    logic              load;
    logic [IDX_W-1:0]  rdNext;
    logic [IDX_W-1:0]  rdAddr;
    logic [31:0]       rdData;
    logic [XLEN-1:0]   expectedPc;

    assign opcodeOk   = isLoopOpcode(in_instr[6:0]);
    assign detect     = in_valid && opcodeOk && in_imm[XLEN-1] && (in_imm[1:0] == 2'b00)
                        && ($signed(in_imm) >= $signed(MIN_IMM));
    assign expectedPc = loopStart_q + (XLEN'(wrIdx_q) << 2);
    assign pcMatch    = (in_pc == expectedPc);
    assign atEnd      = (wrIdx_q == lastIdx_q);
    assign storeWrEn  = ((state_q == ARM) || (state_q == CAPTURE)) && in_valid && pcMatch
                        && !mispredict && !ext_flush && !(atEnd && !opcodeOk);

    // The output register shows entry rdIdx; while it is full, the store is
    // read one entry ahead so the next handshake can load it directly.
    assign atLast = (rdIdx_q == lastIdx_q);
    assign rdNext = atLast ? '0 : rdIdx_q + 1'b1;
    assign rdAddr = outValid_q ? rdNext : rdIdx_q;
    assign load   = (state_q == REPLAY) && !mispredict && !ext_flush && (!outValid_q || out_ready);

    loop_replay_store #(
        .DEPTH(DEPTH)
    ) store (
        .clk      (clk),
        .wrEn_i   (storeWrEn),
        .wrAddr_i (wrIdx_q),
        .wrData_i (in_instr),
        .rdAddr_i (rdAddr),
        .rdData_o (rdData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ext_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (detect) state_d = ARM;
                end
                ARM, CAPTURE: begin
                    if (mispredict) begin
                        state_d = IDLE;
                    end else if (in_valid) begin
                        if (!pcMatch)     state_d = IDLE;
                        else if (!atEnd)  state_d = CAPTURE;
                        else if (opcodeOk) state_d = REPLAY;
                        else              state_d = IDLE;
                    end
                end
                REPLAY: begin
                    if (mispredict) state_d = EXIT;
                end
                EXIT:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Every output is the registered image of the upcoming state, so the
    // status flags line up with the cycle the FSM is actually in.
    always_comb begin
        loopStart_d  = loopStart_q;
        loopEnd_d    = loopEnd_q;
        lastIdx_d    = lastIdx_q;
        wrIdx_d      = wrIdx_q;
        rdIdx_d      = rdIdx_q;
        outValid_d   = outValid_q;
        outPc_d      = outPc_q;
        outInstr_d   = outInstr_q;
        iterCount_d  = iterCount_q;
        redirectPc_d = redirectPc_q;

        if (state_q == IDLE) begin
            wrIdx_d = '0;
            rdIdx_d = '0;
            if (detect) begin
                loopEnd_d   = in_pc;
                loopStart_d = in_pc + in_imm;
                lastIdx_d   = IDX_W'((-in_imm) >> 2);
            end
        end
        if (storeWrEn) begin
            wrIdx_d = wrIdx_q + 1'b1;
        end
        if (load) begin
            outValid_d = 1'b1;
            outPc_d    = loopStart_q + (XLEN'(rdAddr) << 2);
            outInstr_d = rdData;
            if (outValid_q) begin
                rdIdx_d = rdNext;
                if (atLast && (iterCount_q != '1)) begin
                    iterCount_d = iterCount_q + 1'b1;
                end
            end
        end

        if (state_d != REPLAY) outValid_d = 1'b0;
        if (state_d == IDLE)   iterCount_d = '0;
        if (state_d == EXIT)   redirectPc_d = loopEnd_q + XLEN'(4);
        if (ext_flush) begin
            outPc_d      = '0;
            outInstr_d   = '0;
            redirectPc_d = '0;
        end

        fetchStall_d = (state_d == REPLAY);
        redirect_d   = (state_d == EXIT);
        loopActive_d = (state_d == CAPTURE) || (state_d == REPLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loopStart_q  <= '0;
            loopEnd_q    <= '0;
            lastIdx_q    <= '0;
            wrIdx_q      <= '0;
            rdIdx_q      <= '0;
            outValid_q   <= 1'b0;
            outPc_q      <= '0;
            outInstr_q   <= '0;
            fetchStall_q <= 1'b0;
            redirect_q   <= 1'b0;
            redirectPc_q <= '0;
            loopActive_q <= 1'b0;
            iterCount_q  <= '0;
        end else begin
            loopStart_q  <= loopStart_d;
            loopEnd_q    <= loopEnd_d;
            lastIdx_q    <= lastIdx_d;
            wrIdx_q      <= wrIdx_d;
            rdIdx_q      <= rdIdx_d;
            outValid_q   <= outValid_d;
            outPc_q      <= outPc_d;
            outInstr_q   <= outInstr_d;
            fetchStall_q <= fetchStall_d;
            redirect_q   <= redirect_d;
            redirectPc_q <= redirectPc_d;
            loopActive_q <= loopActive_d;
            iterCount_q  <= iterCount_d;
        end
    end

    assign out_valid   = outValid_q;
    assign out_pc      = outPc_q;
    assign out_instr   = outInstr_q;
    assign fetch_stall = fetchStall_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirectPc_q;
    assign loop_active = loopActive_q;
    assign iter_count  = iterCount_q;

endmodule

// File: tb/tb_loop_replay_buffer.sv
// Directed bench for loop_replay_buffer: capture, replay, exit, abort,
// backpressure, flush and asynchronous reset scenarios.
module tb_loop_replay_buffer;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int ITER_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [XLEN-1:0]   in_pc;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_imm;
    logic              mispredict;
    logic              ext_flush;
    logic              out_ready;
    logic              out_valid;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_instr;
    logic              fetch_stall;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic              loop_active;
    logic [ITER_W-1:0] iter_count;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    loop_replay_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ITER_W(ITER_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_instr(in_instr), .in_imm(in_imm), .mispredict(mispredict),
        .ext_flush(ext_flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_pc(out_pc), .out_instr(out_instr), .fetch_stall(fetch_stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .loop_active(loop_active), .iter_count(iter_count)
    );

    function automatic logic [31:0] bodyInstr(input logic [31:0] pc);
        return {pc[24:0], 7'b0010011};
    endfunction

    function automatic logic [31:0] branchInstr(input logic [31:0] pc);
        return {pc[24:0], 7'b1100011};
    endfunction

    function automatic logic [31:0] jalInstr(input logic [31:0] pc);
        return {pc[24:0], 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        in_imm   = imm;
        tick();
        in_valid = 1'b0;
        in_imm   = '0;
    endtask

    // Branch detect, then the full body ending with the branch itself.
    task automatic captureLoop(input logic [31:0] branchPc, input logic [31:0] imm, input logic isJal);
        logic [31:0] startPc;
        logic [31:0] endInstr;
        int n;
        startPc  = branchPc + imm;
        endInstr = isJal ? jalInstr(branchPc) : branchInstr(branchPc);
        n = int'((branchPc - startPc) >> 2);
        fetch(branchPc, endInstr, imm);
        for (int i = 0; i < n; i++) begin
            fetch(startPc + 32'(4 * i), bodyInstr(startPc + 32'(4 * i)), '0);
        end
        fetch(branchPc, endInstr, imm);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_imm = '0;
        mispredict = 1'b0; ext_flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        checkCount++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passCount++;
        checkCount++; if (out_pc !== 32'h0) $display("FAIL rst_out_pc: got %h expected 0", out_pc); else passCount++;
        checkCount++; if (out_instr !== 32'h0) $display("FAIL rst_out_instr: got %h expected 0", out_instr); else passCount++;
        checkCount++; if (fetch_stall !== 1'b0) $display("FAIL rst_fetch_stall: got %b expected 0", fetch_stall); else passCount++;
        checkCount++; if (redirect !== 1'b0) $display("FAIL rst_redirect: got %b expected 0", redirect); else passCount++;
        checkCount++; if (redirect_pc !== 32'h0) $display("FAIL rst_redirect_pc: got %h expected 0", redirect_pc); else passCount++;
        checkCount++; if (loop_active !== 1'b0) $display("FAIL rst_loop_active: got %b expected 0", loop_active); else passCount++;
        checkCount++; if (iter_count !== 8'h0) $display("FAIL rst_iter_count: got %0d expected 0", iter_count); else passCount++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_capture_replay();
        logic [31:0] expPc;
        logic [31:0] expInstr;
        out_ready = 1'b1;
        fetch(32'h1C, branchInstr(32'h1C), 32'hFFFF_FFF4);
        checkCount++; if (loop_active !== 1'b0) $display("FAIL arm_loop_active: got %b expected 0", loop_active); else passCount++;
        fetch(32'h10, bodyInstr(32'h10), '0);
        checkCount++; if (loop_active !== 1'b1) $display("FAIL capture_loop_active: got %b expected 1", loop_active); else passCount++;
        fetch(32'h14, bodyInstr(32'h14), '0);
        fetch(32'h18, bodyInstr(32'h18), '0);
        fetch(32'h1C, branchInstr(32'h1C), 32'hFFFF_FFF4);
        checkCount++; if (fetch_stall !== 1'b1) $display("FAIL replay_stall: got %b expected 1", fetch_stall); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("FAIL replay_first_valid: got %b expected 0", out_valid); else passCount++;
        for (int i = 0; i < 5; i++) begin
            tick();
            expPc    = 32'h10 + 32'(4 * (i % 4));
            expInstr = (expPc == 32'h1C) ? branchInstr(expPc) : bodyInstr(expPc);
            checkCount++; if (out_valid !== 1'b1) $display("FAIL replay_valid[%0d]: got %b expected 1", i, out_valid); else passCount++;
            checkCount++; if (out_pc !== expPc) $display("FAIL replay_pc[%0d]: got %h expected %h", i, out_pc, expPc); else passCount++;
            checkCount++; if (out_instr !== expInstr) $display("FAIL replay_instr[%0d]: got %h expected %h", i, out_instr, expInstr); else passCount++;
            checkCount++; if (iter_count !== ((i == 4) ? 8'd1 : 8'd0)) $display("FAIL replay_iter[%0d]: got %0d expected %0d", i, iter_count, (i == 4) ? 1 : 0); else passCount++;
        end
    endtask

    task automatic test_mispredict();
        mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
        checkCount++; if (redirect !== 1'b1) $display("FAIL exit_redirect: got %b expected 1", redirect); else passCount++;
        checkCount++; if (redirect_pc !== 32'h20) $display("FAIL exit_redirect_pc: got %h expected 00000020", redirect_pc); else passCount++;
        checkCount++; if (fetch_stall !== 1'b0) $display("FAIL exit_stall: got %b expected 0", fetch_stall); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("FAIL exit_valid: got %b expected 0", out_valid); else passCount++;
        checkCount++; if (loop_active !== 1'b0) $display("FAIL exit_loop_active: got %b expected 0", loop_active); else passCount++;
        tick();
        checkCount++; if (redirect !== 1'b0) $display("FAIL exit_redirect_pulse: got %b expected 0", redirect); else passCount++;
        checkCount++; if (iter_count !== 8'd0) $display("FAIL exit_iter_clear: got %0d expected 0", iter_count); else passCount++;
    endtask

    task automatic test_flush_capture();
        fetch(32'h1C, branchInstr(32'h1C), 32'hFFFF_FFF4);
        fetch(32'h10, bodyInstr(32'h10), '0);
        fetch(32'h14, bodyInstr(32'h14), '0);
        checkCount++; if (loop_active !== 1'b1) $display("FAIL flush_pre_active: got %b expected 1", loop_active); else passCount++;
        ext_flush = 1'b1;
        tick();
        ext_flush = 1'b0;
        checkCount++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid); else passCount++;
        checkCount++; if (out_pc !== 32'h0) $display("FAIL flush_out_pc: got %h expected 0", out_pc); else passCount++;
        checkCount++; if (out_instr !== 32'h0) $display("FAIL flush_out_instr: got %h expected 0", out_instr); else passCount++;
        checkCount++; if (fetch_stall !== 1'b0) $display("FAIL flush_fetch_stall: got %b expected 0", fetch_stall); else passCount++;
        checkCount++; if (redirect_pc !== 32'h0) $display("FAIL flush_redirect_pc: got %h expected 0", redirect_pc); else passCount++;
        checkCount++; if (loop_active !== 1'b0) $display("FAIL flush_loop_active: got %b expected 0", loop_active); else passCount++;
        checkCount++; if (iter_count !== 8'h0) $display("FAIL flush_iter_count: got %0d expected 0", iter_count); else passCount++;
        for (int i = 0; i < 3; i++) begin
            checkCount++; if (redirect !== 1'b0) $display("FAIL flush_redirect[%0d]: got %b expected 0", i, redirect); else passCount++;
            fetch(32'h18 + 32'(4 * i), bodyInstr(32'h18 + 32'(4 * i)), '0);
        end
        checkCount++; if (loop_active !== 1'b0) $display("FAIL flush_stays_idle: got %b expected 0", loop_active); else passCount++;
    endtask

    task automatic test_depth_limits();
        logic [31:0] expPc;
        captureLoop(32'h100, 32'hFFFF_FFC4, 1'b1);
        checkCount++; if (fetch_stall !== 1'b1) $display("FAIL d16_stall: got %b expected 1", fetch_stall); else passCount++;
        for (int i = 0; i < 17; i++) begin
            tick();
            expPc = 32'hC4 + 32'(4 * (i % 16));
            checkCount++; if (out_pc !== expPc) $display("FAIL d16_pc[%0d]: got %h expected %h", i, out_pc, expPc); else passCount++;
        end
        checkCount++; if (out_instr !== bodyInstr(32'hC4)) $display("FAIL d16_instr_wrap: got %h expected %h", out_instr, bodyInstr(32'hC4)); else passCount++;
        checkCount++; if (iter_count !== 8'd1) $display("FAIL d16_iter: got %0d expected 1", iter_count); else passCount++;
        mispredict = 1'b1;
        tick();
        mispredict = 1'b0;
        checkCount++; if (redirect_pc !== 32'h104) $display("FAIL d16_redirect_pc: got %h expected 00000104", redirect_pc); else passCount++;
        tick();
        fetch(32'h100, jalInstr(32'h100), 32'hFFFF_FFC0);
        fetch(32'hC0, bodyInstr(32'hC0), '0);
        checkCount++; if (loop_active !== 1'b0) $display("FAIL too_far_ignored: got %b expected 0", loop_active); else passCount++;
        fetch(32'h100, jalInstr(32'h100), 32'h0000_0008);
        fetch(32'h108, bodyInstr(32'h108), '0);
        checkCount++; if (loop_active !== 1'b0) $display("FAIL forward_ignored: got %b expected 0", loop_active); else passCount++;
    endtask

    task automatic test_abort();
        fetch(32'h1C, branchInstr(32'h1C), 32'hFFFF_FFF4);
        fetch(32'h10, bodyInstr(32'h10), '0);
        checkCount++; if (loop_active !== 1'b1) $display("FAIL abort_capture_active: got %b expected 1", loop_active); else passCount++;
        fetch(32'h30, bodyInstr(32'h30), '0);
        checkCount++; if (loop_active !== 1'b0) $display("FAIL abort_capture: got %b expected 0", loop_active); else passCount++;
        fetch(32'h1C, branchInstr(32'h1C), 32'hFFFF_FFF4);
        fetch(32'h40, bodyInstr(32'h40), '0);
        fetch(32'h10, bodyInstr(32'h10), '0);
        checkCount++; if (loop_active !== 1'b0) $display("FAIL abort_arm: got %b expected 0", loop_active); else passCount++;
    endtask

    task automatic test_backpressure();
        logic [31:0] expPc;
        out_ready = 1'b1;
        captureLoop(32'h1C, 32'hFFFF_FFF4, 1'b0);
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkCount++; if (out_pc !== 32'h14) $display("FAIL stall_pc[%0d]: got %h expected 00000014", i, out_pc); else passCount++;
            checkCount++; if (out_instr !== bodyInstr(32'h14)) $display("FAIL stall_instr[%0d]: got %h expected %h", i, out_instr, bodyInstr(32'h14)); else passCount++;
            checkCount++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); else passCount++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expPc = (i == 2) ? 32'h10 : 32'h18 + 32'(4 * i);
            checkCount++; if (out_pc !== expPc) $display("FAIL resume_pc[%0d]: got %h expected %h", i, out_pc, expPc); else passCount++;
        end
        checkCount++; if (iter_count !== 8'd1) $display("FAIL resume_iter: got %0d expected 1", iter_count); else passCount++;
    endtask

    task automatic test_reset_mid_replay();
        #2;
        reset = 1'b1;
        #1;
        checkCount++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b expected 0", out_valid); else passCount++;
        checkCount++; if (out_pc !== 32'h0) $display("FAIL arst_out_pc: got %h expected 0", out_pc); else passCount++;
        checkCount++; if (out_instr !== 32'h0) $display("FAIL arst_out_instr: got %h expected 0", out_instr); else passCount++;
        checkCount++; if (fetch_stall !== 1'b0) $display("FAIL arst_fetch_stall: got %b expected 0", fetch_stall); else passCount++;
        checkCount++; if (redirect_pc !== 32'h0) $display("FAIL arst_redirect_pc: got %h expected 0", redirect_pc); else passCount++;
        checkCount++; if (loop_active !== 1'b0) $display("FAIL arst_loop_active: got %b expected 0", loop_active); else passCount++;
        checkCount++; if (iter_count !== 8'h0) $display("FAIL arst_iter_count: got %0d expected 0", iter_count); else passCount++;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++; if (redirect !== 1'b0) $display("FAIL arst_redirect[%0d]: got %b expected 0", i, redirect); else passCount++;
            checkCount++; if (out_valid !== 1'b0) $display("FAIL arst_idle_valid[%0d]: got %b expected 0", i, out_valid); else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_capture_replay();
        test_mispredict();
        test_flush_capture();
        test_depth_limits();
        test_abort();
        test_backpressure();
        test_reset_mid_replay();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
